// File: rtl/loteria_pkg.sv
// Shared types for the lottery ticket scheduler: prize codes, FSM states,
// BCD ticket layout and the digit-validity helper.
package loteria_pkg;

   localparam int TICKET_W   = 20;
   localparam int NUM_DIGITS = 5;

   typedef logic [3:0]          digit_t;
   typedef logic [TICKET_W-1:0] ticket_t;

   localparam digit_t DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      PRIZE_NONE    = 2'b00,
      PRIZE_1       = 2'b01,
      PRIZE_2       = 2'b10,
      PRIZE_INVALID = 2'b11
   } prize_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } sched_state_t;

   function automatic logic ticket_has_bad_digit(input ticket_t t);
      logic bad;
      bad = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (digit_t'(t[4*d +: 4]) > DIGIT_MAX) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic prize_is_win(input prize_t p);
      return (p == PRIZE_1) || (p == PRIZE_2);
   endfunction

endpackage

// File: rtl/loteria_ticket_scheduler_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// The pointer register itself is owned by the scheduler.
module loteria_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     pick,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      int   k;
      logic found;
      k     = 0;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int off = 0; off < N; off++) begin
         k = (int'(ptr) + off) % N;
         if (!found && req[k]) begin
            found   = 1'b1;
            pick[k] = 1'b1;
            idx     = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/loteria_ticket_scheduler.sv
// Round-robin scheduler sharing one lottery checker among N stations.
// Optional WAIT-state timeout is compiled in with LOTERIA_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | arbitrate pending requests, latch winner's ticket
// ISSUE   | chk_start pulse to the checker
// WAIT    | hold until chk_done (or timeout when enabled)
// RESPOND | return prize to the granted station, update stats
module loteria_ticket_scheduler
   import loteria_pkg::*;
#(
   parameter int N_STATIONS     = 4,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_STATIONS-1:0]        req,
   input  logic [TICKET_W*N_STATIONS-1:0] ticket,
   output logic [N_STATIONS-1:0]        grant,
   output logic [N_STATIONS-1:0]        resp_valid,
   output logic [1:0]                   resp_prize,
   output logic                         chk_start,
   output logic [TICKET_W-1:0]          chk_ticket,
   input  logic                         chk_done,
   input  logic [1:0]                   chk_prize,
   output logic                         busy,
   output logic [CNT_W-1:0]             cnt_tickets,
   output logic [CNT_W-1:0]             cnt_wins
);

   localparam int IDX_W = $clog2(N_STATIONS);

   sched_state_t            state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   ticket_t                 ticket_q, ticket_d;
   prize_t                  prize_q, prize_d;
   logic [N_STATIONS-1:0]   grant_q, grant_d;
   logic [N_STATIONS-1:0]   resp_valid_q, resp_valid_d;
   prize_t                  resp_prize_q, resp_prize_d;
   logic                    chk_start_q, chk_start_d;
   logic                    busy_q, busy_d;
   logic [CNT_W-1:0]        cnt_tickets_q, cnt_tickets_d;
   logic [CNT_W-1:0]        cnt_wins_q, cnt_wins_d;

   logic [N_STATIONS-1:0]   arb_pick;
   logic [IDX_W-1:0]        arb_idx;
   ticket_t                 sel_ticket;

`ifdef LOTERIA_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Loaded so the response lands TIMEOUT_CYCLES cycles after WAIT entry.
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 2);
   logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
`else
   logic [31:0]             unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   loteria_rr_arbiter #(
      .N     (N_STATIONS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req  (req),
      .ptr  (ptr_q),
      .pick (arb_pick),
      .idx  (arb_idx)
   );

   always_comb begin
      sel_ticket = '0;
      for (int i = 0; i < N_STATIONS; i++) begin
         if (arb_idx == IDX_W'(i)) sel_ticket = ticket[TICKET_W*i +: TICKET_W];
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      idx_d         = idx_q;
      ticket_d      = ticket_q;
      prize_d       = prize_q;
      grant_d       = '0;
      resp_valid_d  = '0;
      resp_prize_d  = PRIZE_NONE;
      chk_start_d   = 1'b0;
      cnt_tickets_d = cnt_tickets_q;
      cnt_wins_d    = cnt_wins_q;
`ifdef LOTERIA_TIMEOUT_EN
      wait_cnt_d    = wait_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               idx_d    = arb_idx;
               ticket_d = sel_ticket;
               grant_d  = arb_pick;
               if (ticket_has_bad_digit(sel_ticket)) begin
                  prize_d = PRIZE_INVALID;
                  state_d = S_RESPOND;
               end else begin
                  chk_start_d = 1'b1;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef LOTERIA_TIMEOUT_EN
            wait_cnt_d = WAIT_LOAD;
`endif
         end
         S_WAIT: begin
            if (chk_done) begin
               prize_d = prize_t'(chk_prize);
               state_d = S_RESPOND;
            end
`ifdef LOTERIA_TIMEOUT_EN
            else if (wait_cnt_q == '0) begin
               prize_d = PRIZE_INVALID;
               state_d = S_RESPOND;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
`endif
         end
         S_RESPOND: begin
            resp_valid_d  = N_STATIONS'(1) << idx_q;
            resp_prize_d  = prize_q;
            cnt_tickets_d = (&cnt_tickets_q) ? cnt_tickets_q : cnt_tickets_q + 1'b1;
            if (prize_is_win(prize_q) && !(&cnt_wins_q)) cnt_wins_d = cnt_wins_q + 1'b1;
            ptr_d   = (idx_q == IDX_W'(N_STATIONS - 1)) ? '0 : idx_q + 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         idx_q         <= '0;
         ticket_q      <= '0;
         prize_q       <= PRIZE_NONE;
         grant_q       <= '0;
         resp_valid_q  <= '0;
         resp_prize_q  <= PRIZE_NONE;
         chk_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         cnt_tickets_q <= '0;
         cnt_wins_q    <= '0;
`ifdef LOTERIA_TIMEOUT_EN
         wait_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         idx_q         <= idx_d;
         ticket_q      <= ticket_d;
         prize_q       <= prize_d;
         grant_q       <= grant_d;
         resp_valid_q  <= resp_valid_d;
         resp_prize_q  <= resp_prize_d;
         chk_start_q   <= chk_start_d;
         busy_q        <= busy_d;
         cnt_tickets_q <= cnt_tickets_d;
         cnt_wins_q    <= cnt_wins_d;
`ifdef LOTERIA_TIMEOUT_EN
         wait_cnt_q    <= wait_cnt_d;
`endif
      end
   end

   assign grant       = grant_q;
   assign resp_valid  = resp_valid_q;
   assign resp_prize  = resp_prize_q;
   assign chk_start   = chk_start_q;
   assign chk_ticket  = ticket_q;
   assign busy        = busy_q;
   assign cnt_tickets = cnt_tickets_q;
   assign cnt_wins    = cnt_wins_q;

endmodule
